comporta_agendador: RTL and testbench

Dispense scheduler that sequences the gate control unit. It periodically requests a gate opening and holds `abrirComporta` until the measured weight reaches a target or a timeout expires. It then waits for the gate to report closed and counts completed doses. It sits between the system's top-level control/config registers and the gate control unit, driving that unit's `abrirComporta` and `comando` inputs.

---
 rtl/comporta_pkg.sv | 20 ++
 rtl/comporta_agendador_temporizador.sv | 41 ++++
 rtl/comporta_agendador.sv | 179 +++++++++++++++++
 tb/tb_comporta_agendador.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/comporta_pkg.sv
// comporta_pkg
// Shared definitions for the dispense scheduler (comporta_agendador):
// state encoding as exported on dbEstado, its width, and the code that is
// never produced by the FSM (any such value falls back to OCIOSO).
package comporta_pkg;

   localparam int DBESTADO_W = 4;

   typedef enum logic [DBESTADO_W-1:0] {
      OCIOSO   = 4'd0,
      ESPERA   = 4'd1,
      VERIFICA = 4'd2,
      ABRINDO  = 4'd3,
      FECHANDO = 4'd4,
      ERRO     = 4'd5
   } estado_t;

   localparam logic [DBESTADO_W-1:0] ESTADO_INVALIDO = 4'd15;

endpackage

// File: rtl/comporta_agendador_temporizador.sv
// comporta_temporizador
// Up-counter with synchronous clear, count enable and terminal flag.
// terminal_o is high while the count equals CICLOS-1; counting past the
// terminal value wraps to 0.
// Ports:
//   clock      in  system clock
//   reset      in  synchronous active-high reset
//   limpa_i    in  clear count to 0 (wins over habilita_i)
//   habilita_i in  advance count this cycle
//   terminal_o out count == CICLOS-1
module comporta_temporizador #(
   parameter int CICLOS = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic limpa_i,
   input  logic habilita_i,
   output logic terminal_o
);

   localparam int W = (CICLOS > 1) ? $clog2(CICLOS) : 1;
   localparam logic [W-1:0] ULTIMO = W'(CICLOS - 1);

   logic [W-1:0] contagem_q, contagem_d;

   assign terminal_o = (contagem_q == ULTIMO);

   always_comb begin
      contagem_d = contagem_q;
      if (limpa_i)
         contagem_d = '0;
      else if (habilita_i)
         contagem_d = terminal_o ? '0 : contagem_q + W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) contagem_q <= '0;
      else       contagem_q <= contagem_d;
   end

endmodule

// File: rtl/comporta_agendador.sv
// comporta_agendador
// Dispense scheduler in front of the gate control unit. Periodically asks
// for a gate opening, holds abrirComporta until the weight reaches the
// target or a timeout expires, waits for the gate to close and counts doses.
// Optional feature macro: COMPORTA_MANUAL_EN (manual dose requests).
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   habilita           level, enables automatic dosing
//   pedidoManual       pulse, manual dose request (macro only)
//   limpaErro          pulse, clears error flags / leaves ERRO
//   peso, pesoAlvo     measured and target weight (unsigned)
//   pesoMaxIgualZero   reservoir empty
//   comportaFechada    gate unit idle and closed
//   abrirComporta      open request to gate unit
//   comando            manual override to gate unit
//   ocupado            dose in progress (VERIFICA/ABRINDO/FECHANDO)
//   erroTimeout        sticky, opening timed out
//   erroVazio          sticky, reservoir empty at check
//   doses              completed doses, wraps
//   dbEstado           current state code
module comporta_agendador
   import comporta_pkg::*;
#(
   parameter int PERIODO_CICLOS = 1000,
   parameter int TIMEOUT_CICLOS = 5000,
   parameter int PESO_W         = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  habilita,
   input  logic                  pedidoManual,
   input  logic                  limpaErro,
   input  logic [PESO_W-1:0]     peso,
   input  logic [PESO_W-1:0]     pesoAlvo,
   input  logic                  pesoMaxIgualZero,
   input  logic                  comportaFechada,
   output logic                  abrirComporta,
   output logic                  comando,
   output logic                  ocupado,
   output logic                  erroTimeout,
   output logic                  erroVazio,
   output logic [7:0]            doses,
   output logic [DBESTADO_W-1:0] dbEstado
);

   estado_t    estado_q, estado_d;
   logic       manual_q, manual_d;
   logic       erroTimeout_q, erroTimeout_d;
   logic       erroVazio_q, erroVazio_d;
   logic [7:0] doses_q, doses_d;
   logic       pedido;
   logic       alvo_ok;
   logic       fim_periodo, fim_timeout;

   assign alvo_ok = (peso >= pesoAlvo);

   // Counters are held at 0 outside their state, so entering the state
   // always starts the count from zero.
   comporta_temporizador #(.CICLOS(PERIODO_CICLOS)) u_periodo (
      .clock      (clock),
      .reset      (reset),
      .limpa_i    (estado_q != ESPERA),
      .habilita_i (estado_q == ESPERA),
      .terminal_o (fim_periodo)
   );

   comporta_temporizador #(.CICLOS(TIMEOUT_CICLOS)) u_timeout (
      .clock      (clock),
      .reset      (reset),
      .limpa_i    (estado_q != ABRINDO),
      .habilita_i (estado_q == ABRINDO),
      .terminal_o (fim_timeout)
   );

`ifdef COMPORTA_MANUAL_EN
   assign pedido = pedidoManual;

   always_ff @(posedge clock) begin
      if (reset) manual_q <= 1'b0;
      else       manual_q <= manual_d;
   end

   assign comando = manual_q && (estado_q == VERIFICA || estado_q == ABRINDO);
`else
   logic unused_manual;
   assign unused_manual = ^{pedidoManual, manual_d};
   assign pedido   = 1'b0;
   assign manual_q = 1'b0;
   assign comando  = 1'b0;
`endif

   always_comb begin
      estado_d      = estado_q;
      manual_d      = manual_q;
      erroTimeout_d = erroTimeout_q;
      erroVazio_d   = erroVazio_q;
      doses_d       = doses_q;
      // A timeout raised in the same cycle as limpaErro stays set.
      if (limpaErro) erroTimeout_d = 1'b0;
      case (estado_q)
         OCIOSO: begin
            if (habilita)
               estado_d = ESPERA;
            else if (pedido && comportaFechada) begin
               estado_d = VERIFICA;
               manual_d = 1'b1;
            end
         end
         ESPERA: begin
            if (!habilita)
               estado_d = OCIOSO;
            else if (pedido) begin
               estado_d = VERIFICA;
               manual_d = 1'b1;
            end else if (fim_periodo)
               estado_d = VERIFICA;
         end
         VERIFICA: begin
            if (alvo_ok) begin
               // Skipped dose: drop the manual mark so the next automatic
               // dose is not treated as manual.
               estado_d = ESPERA;
               manual_d = 1'b0;
            end else if (pesoMaxIgualZero && !manual_q) begin
               estado_d    = ERRO;
               erroVazio_d = 1'b1;
            end else
               estado_d = ABRINDO;
         end
         ABRINDO: begin
            if (alvo_ok)
               estado_d = FECHANDO;
            else if (fim_timeout) begin
               estado_d      = FECHANDO;
               erroTimeout_d = 1'b1;
            end else if (!habilita && !manual_q)
               estado_d = FECHANDO;
         end
         FECHANDO: begin
            if (comportaFechada) begin
               doses_d  = doses_q + 8'd1;
               manual_d = 1'b0;
               estado_d = habilita ? ESPERA : OCIOSO;
            end
         end
         ERRO: begin
            if (limpaErro) begin
               estado_d      = OCIOSO;
               erroTimeout_d = 1'b0;
               erroVazio_d   = 1'b0;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q      <= OCIOSO;
         erroTimeout_q <= 1'b0;
         erroVazio_q   <= 1'b0;
         doses_q       <= 8'd0;
      end else begin
         estado_q      <= estado_d;
         erroTimeout_q <= erroTimeout_d;
         erroVazio_q   <= erroVazio_d;
         doses_q       <= doses_d;
      end
   end

   assign abrirComporta = (estado_q == ABRINDO);
   assign ocupado       = (estado_q == VERIFICA) || (estado_q == ABRINDO) ||
                          (estado_q == FECHANDO);
   assign dbEstado      = estado_q;
   assign erroTimeout   = erroTimeout_q;
   assign erroVazio     = erroVazio_q;
   assign doses         = doses_q;

endmodule

// File: tb/tb_comporta_agendador.sv
// Directed bench for comporta_agendador with PERIODO_CICLOS=8,
// TIMEOUT_CICLOS=16. Inputs change and outputs are sampled on the falling
// edge; the DUT acts on the rising edge.
module tb_comporta_agendador;

   localparam int PW = 12;

   logic          clock = 1'b0;
   logic          reset;
   logic          habilita, pedidoManual, limpaErro;
   logic [PW-1:0] peso, pesoAlvo;
   logic          pesoMaxIgualZero, comportaFechada;
   logic          abrirComporta, comando, ocupado, erroTimeout, erroVazio;
   logic [7:0]    doses;
   logic [3:0]    dbEstado;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_doses;

   always #5 clock = ~clock;

   comporta_agendador #(
      .PERIODO_CICLOS (8),
      .TIMEOUT_CICLOS (16),
      .PESO_W         (PW)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .habilita         (habilita),
      .pedidoManual     (pedidoManual),
      .limpaErro        (limpaErro),
      .peso             (peso),
      .pesoAlvo         (pesoAlvo),
      .pesoMaxIgualZero (pesoMaxIgualZero),
      .comportaFechada  (comportaFechada),
      .abrirComporta    (abrirComporta),
      .comando          (comando),
      .ocupado          (ocupado),
      .erroTimeout      (erroTimeout),
      .erroVazio        (erroVazio),
      .doses            (doses),
      .dbEstado         (dbEstado)
   );

   task automatic ciclo(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin : estimulo
      int n_doses;
      logic [7:0] ant;
      reset = 1'b1; habilita = 1'b0; pedidoManual = 1'b0; limpaErro = 1'b0;
      peso = '0; pesoAlvo = '0; pesoMaxIgualZero = 1'b0; comportaFechada = 1'b1;
      ciclo(2);
      chk("rst_estado", 32'(dbEstado), 0);
      chk("rst_saidas", 32'({abrirComporta, comando, ocupado, erroTimeout, erroVazio}), 0);
      chk("rst_doses", 32'(doses), 0);
      reset = 1'b0;

      // 1: normal dose, target reached after 5 open cycles
      pesoAlvo = 12'd100; peso = 12'd0; habilita = 1'b1;
      ciclo(1);
      chk("t1_espera", 32'(dbEstado), 1);
      ciclo(8);
      chk("t1_verifica", 32'({dbEstado, ocupado, abrirComporta}), {4'd2, 1'b1, 1'b0});
      ciclo(1);
      chk("t1_abre_9", 32'({dbEstado, abrirComporta, comando}), {4'd3, 1'b1, 1'b0});
      ciclo(5);
      chk("t1_aberto_a5", 32'(abrirComporta), 1);
      peso = 12'd100; comportaFechada = 1'b0;
      ciclo(1);
      chk("t1_fecha", 32'({dbEstado, abrirComporta}), {4'd4, 1'b0});
      ciclo(1);
      chk("t1_espera_fechada", 32'({dbEstado, doses}), {4'd4, 8'd0});
      comportaFechada = 1'b1;
      ciclo(1);
      chk("t1_dose", 32'({dbEstado, doses}), {4'd1, 8'd1});

      // 4: weight already above target at VERIFICA -> dose skipped
      peso = 12'd120;
      ciclo(8);
      chk("t4_verifica", 32'(dbEstado), 2);
      ciclo(1);
      chk("t4_pula", 32'({dbEstado, abrirComporta, doses}), {4'd1, 1'b0, 8'd1});

      // 2: timeout, abrirComporta high exactly 16 cycles
      peso = 12'd0;
      ciclo(9);
      chk("t2_abre", 32'(abrirComporta), 1);
      ciclo(15);
      chk("t2_ultimo_aberto", 32'({abrirComporta, erroTimeout}), {1'b1, 1'b0});
      ciclo(1);
      chk("t2_timeout", 32'({dbEstado, abrirComporta, erroTimeout}), {4'd4, 1'b0, 1'b1});
      ciclo(1);
      chk("t2_volta_espera", 32'({dbEstado, doses, erroTimeout}), {4'd1, 8'd2, 1'b1});
      limpaErro = 1'b1;
      ciclo(1);
      limpaErro = 1'b0;
      chk("t2_limpa", 32'({dbEstado, erroTimeout}), {4'd1, 1'b0});

      // 3: empty reservoir at VERIFICA -> ERRO
      pesoMaxIgualZero = 1'b1;
      ciclo(7);
      chk("t3_verifica", 32'(dbEstado), 2);
      ciclo(1);
      chk("t3_erro", 32'({dbEstado, erroVazio, abrirComporta, ocupado}), {4'd5, 1'b1, 1'b0, 1'b0});
      habilita = 1'b0;
      ciclo(2);
      chk("t3_preso", 32'(dbEstado), 5);
      limpaErro = 1'b1;
      ciclo(1);
      limpaErro = 1'b0;
      chk("t3_limpa", 32'({dbEstado, erroVazio}), {4'd0, 1'b0});

      // 5: manual request in OCIOSO with empty reservoir
      exp_doses = 8'd2;
      pedidoManual = 1'b1;
      ciclo(1);
      pedidoManual = 1'b0;
`ifdef COMPORTA_MANUAL_EN
      chk("t5_verifica", 32'({dbEstado, comando}), {4'd2, 1'b1});
      ciclo(1);
      chk("t5_abrindo", 32'({dbEstado, comando, abrirComporta}), {4'd3, 1'b1, 1'b1});
      peso = 12'd100;
      ciclo(1);
      chk("t5_fecha", 32'({dbEstado, comando}), {4'd4, 1'b0});
      ciclo(1);
      exp_doses = 8'd3;
`else
      chk("t5_ignora", 32'({dbEstado, comando}), {4'd0, 1'b0});
      ciclo(1);
      chk("t5_ignora2", 32'({dbEstado, abrirComporta}), {4'd0, 1'b0});
`endif
      chk("t5_doses", 32'({dbEstado, doses}), {4'd0, exp_doses});

      // 6: reset in ABRINDO, then dose counter wrap
      pesoMaxIgualZero = 1'b0; peso = 12'd0; habilita = 1'b1;
      ciclo(10);
      chk("t6_abrindo", 32'({dbEstado, abrirComporta}), {4'd3, 1'b1});
      reset = 1'b1;
      ciclo(1);
      reset = 1'b0;
      chk("t6_reset", 32'({dbEstado, abrirComporta, comando, ocupado, erroTimeout, erroVazio, doses}), 0);

      n_doses = 0;
      ant = doses;
      for (int i = 0; i < 8000 && n_doses < 256; i++) begin
         ciclo(1);
         if (doses !== ant) begin
            n_doses++;
            ant = doses;
            if (n_doses == 255) chk("t6_255", 32'(doses), 255);
         end
      end
      chk("t6_contagem", n_doses, 256);
      chk("t6_wrap", 32'(doses), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
